// File: rtl/fifo_pkg.sv
// Shared helpers for the narrow-to-wide packing FIFO.
package fifo_pkg;

  function automatic int unsigned depth(input int unsigned aw);
    return 2 ** aw;
  endfunction

  typedef enum logic [1:0] {
    ACC_NONE = 2'b00,
    ACC_RD   = 2'b01,
    ACC_WR   = 2'b10,
    ACC_BOTH = 2'b11
  } acc_t;

endpackage

// File: rtl/reg_file_2r.sv
// Register file: one synchronous write port, two combinational read ports.
module reg_file_2r #(
  parameter int AW = 9,
  parameter int DW = 8
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_a_i,
  input  logic [AW-1:0] raddr_b_i,
  output logic [DW-1:0] rdata_a_o,
  output logic [DW-1:0] rdata_b_o
);

  logic [DW-1:0] mem_q [2**AW];

  // Contents are deliberately left unreset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/fifo_narrow_to_wide.sv
// FIFO packing pairs of narrow writes into one wide, little-endian read word.
module fifo_narrow_to_wide
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    wr_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    rd_i,
  output logic [2*DATA_WIDTH-1:0] rd_data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [ADDR_WIDTH:0]     level_o
);

  localparam int unsigned DEPTH = depth(ADDR_WIDTH);
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;

  logic [AW-1:0] w_ptr_q, w_ptr_d;
  logic [AW-1:0] r_ptr_q, r_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          wr_ok, rd_ok;
  logic [DW-1:0] lo_data, hi_data;
  acc_t          acc;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q < (AW+1)'(2));
  assign level_o = level_q;

  assign wr_ok = wr_i && !full_o;
  assign rd_ok = rd_i && !empty_o;
  assign acc   = acc_t'({wr_ok, rd_ok});

  reg_file_2r #(
    .AW(AW),
    .DW(DW)
  ) u_rf (
    .clk_i    (clk_i),
    .we_i     (wr_ok),
    .waddr_i  (w_ptr_q),
    .wdata_i  (wr_data_i),
    .raddr_a_i(r_ptr_q),
    .raddr_b_i(r_ptr_q | AW'(1)),
    .rdata_a_o(lo_data),
    .rdata_b_o(hi_data)
  );

  assign rd_data_o = empty_o ? '0 : {hi_data, lo_data};

  always_comb begin
    w_ptr_d = w_ptr_q;
    r_ptr_d = r_ptr_q;
    level_d = level_q;
    unique case (acc)
      ACC_WR: begin
        w_ptr_d = w_ptr_q + AW'(1);
        level_d = level_q + (AW+1)'(1);
      end
      ACC_RD: begin
        r_ptr_d = r_ptr_q + AW'(2);
        level_d = level_q - (AW+1)'(2);
      end
      ACC_BOTH: begin
        w_ptr_d = w_ptr_q + AW'(1);
        r_ptr_d = r_ptr_q + AW'(2);
        level_d = level_q - (AW+1)'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      w_ptr_q <= '0;
      r_ptr_q <= '0;
      level_q <= '0;
    end else begin
      w_ptr_q <= w_ptr_d;
      r_ptr_q <= r_ptr_d;
      level_q <= level_d;
    end
  end

endmodule

// File: tb/tb_fifo_narrow_to_wide.sv
// Randomised and directed bench for fifo_narrow_to_wide against a byte-queue model.
module tb_fifo_narrow_to_wide;

  localparam int AW = 2;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr;
  logic [DW-1:0] wr_data;
  logic          rd;
  logic [2*DW-1:0] rd_data;
  logic          full, empty;
  logic [AW:0]   level;

  int checks = 0;
  int errors = 0;
  byte unsigned q[$];

  always #5 clk = ~clk;

  fifo_narrow_to_wide #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .wr_i     (wr),
    .wr_data_i(wr_data),
    .rd_i     (rd),
    .rd_data_o(rd_data),
    .full_o   (full),
    .empty_o  (empty),
    .level_o  (level)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] model_rd();
    if (q.size() < 2) return 16'h0;
    return {q[1], q[0]};
  endfunction

  task automatic chk_model(input string tag);
    chk({tag, ".level"}, 32'(level), 32'(q.size()));
    chk({tag, ".full"}, 32'(full), 32'(q.size() == 4));
    chk({tag, ".empty"}, 32'(empty), 32'(q.size() < 2));
    chk({tag, ".data"}, 32'(rd_data), 32'(model_rd()));
  endtask

  // Inputs driven 1 time unit after a rising edge, outputs checked before the next.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r);
    bit wa, ra;
    wr = w;
    wr_data = d;
    rd = r;
    #1;
    chk_model("pre");
    wa = w && (q.size() < 4);
    ra = r && (q.size() >= 2);
    @(posedge clk);
    if (ra) begin
      void'(q.pop_front());
      void'(q.pop_front());
    end
    if (wa) q.push_back(d);
    #1;
    wr = 1'b0;
    rd = 1'b0;
    chk_model("post");
  endtask

  initial begin
    rst = 1'b1;
    wr = 1'b0;
    rd = 1'b0;
    wr_data = '0;
    #1;
    chk("rst.level", 32'(level), 0);
    chk("rst.empty", 32'(empty), 1);
    chk("rst.full", 32'(full), 0);
    chk("rst.data", 32'(rd_data), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Basic pack
    cyc(1, 8'h11, 0);
    chk("bp.lvl1", 32'(level), 1);
    chk("bp.emp1", 32'(empty), 1);
    cyc(1, 8'h22, 0);
    chk("bp.data", 32'(rd_data), 32'h2211);
    chk("bp.emp2", 32'(empty), 0);
    cyc(0, 8'h00, 1);
    chk("bp.rdemp", 32'(empty), 1);
    chk("bp.rd0", 32'(rd_data), 0);

    // Odd leftover
    cyc(1, 8'hAA, 0);
    cyc(1, 8'hBB, 0);
    cyc(1, 8'hCC, 0);
    chk("odd.data", 32'(rd_data), 32'hBBAA);
    cyc(0, 8'h00, 1);
    chk("odd.lvl", 32'(level), 1);
    chk("odd.emp", 32'(empty), 1);
    cyc(1, 8'hDD, 0);
    chk("odd.pair", 32'(rd_data), 32'hDDCC);
    cyc(0, 8'h00, 1);

    // Full / drop
    for (int i = 1; i <= 4; i++) cyc(1, 8'(i), 0);
    chk("full.f", 32'(full), 1);
    chk("full.lvl", 32'(level), 4);
    cyc(1, 8'h05, 0);
    chk("full.drop", 32'(level), 4);
    chk("full.rd1", 32'(rd_data), 32'h0201);
    cyc(0, 8'h00, 1);
    chk("full.rd2", 32'(rd_data), 32'h0403);
    cyc(0, 8'h00, 1);
    chk("full.emp", 32'(empty), 1);

    // Wrap-around
    for (int i = 0; i < 6; i++) begin
      cyc(1, 8'(2 * i), 0);
      cyc(1, 8'(2 * i + 1), 0);
      chk("wrap.data", 32'(rd_data), 32'({8'(2 * i + 1), 8'(2 * i)}));
      cyc(0, 8'h00, 1);
    end

    // Simultaneous at level 3 and at full
    for (int i = 0; i < 3; i++) cyc(1, 8'h30 + 8'(i), 0);
    cyc(1, 8'h33, 1);
    chk("sim3.lvl", 32'(level), 2);
    chk("sim3.data", 32'(rd_data), 32'h3332);
    cyc(1, 8'h34, 0);
    cyc(1, 8'h35, 0);
    cyc(1, 8'h36, 1);
    chk("sim4.lvl", 32'(level), 2);
    chk("sim4.data", 32'(rd_data), 32'h3534);
    cyc(0, 8'h00, 1);

    // Same-cycle write and read at level 1
    cyc(1, 8'h41, 0);
    cyc(1, 8'h42, 1);
    chk("sim1.lvl", 32'(level), 2);
    cyc(0, 8'h00, 1);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) cyc(1, 8'h50 + 8'(i), 0);
    #2 rst = 1'b1;
    #1;
    chk("arst.level", 32'(level), 0);
    chk("arst.empty", 32'(empty), 1);
    chk("arst.full", 32'(full), 0);
    chk("arst.data", 32'(rd_data), 0);
    q.delete();
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(1, 8'h77, 0);
    cyc(1, 8'h88, 0);
    chk("arst.pair", 32'(rd_data), 32'h8877);
    cyc(0, 8'h00, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_narrow_to_wide.md
# fifo_narrow_to_wide

Synchronous FIFO with data width conversion from narrow to wide. The write side accepts DATA_WIDTH-bit words. The read side delivers 2·DATA_WIDTH-bit words, each formed by packing two consecutive writes. It is the packing counterpart of the team's wide-to-narrow conversion FIFO and sits between byte-oriented producers and word-oriented consumers.

## Interface
Parameters:
- ADDR_WIDTH, default 9: log2 of storage depth in narrow words. Must be ≥ 1, so depth is always even.
- DATA_WIDTH, default 8: narrow (write) word width. The read word is 2·DATA_WIDTH.

Ports (one clock; reset is asynchronous and active-high):
- clk_i, input, 1: clock, rising edge.
- rst_i, input, 1: asynchronous, active-high reset.
- wr_i, input, 1: write request.
- wr_data_i, input, DATA_WIDTH: narrow write data.
- rd_i, input, 1: read request. Pops one wide word.
- rd_data_o, output, 2·DATA_WIDTH: wide read data, first-word-fall-through.
- full_o, output, 1: no room for a narrow write.
- empty_o, output, 1: fewer than 2 narrow words stored, so no wide word is available.
- level_o, output, ADDR_WIDTH+1: number of narrow words stored.

## Operation
- Storage: 2^ADDR_WIDTH × DATA_WIDTH register file, one write port and two combinational read ports.
- Write pointer w_ptr (ADDR_WIDTH bits) advances by 1 per accepted write.
- Read pointer r_ptr (ADDR_WIDTH bits) advances by 2 per accepted read. Its LSB is always 0.
- Packing is little-endian: rd_data_o = {mem[r_ptr+1], mem[r_ptr]}. The earlier-written word goes in the low half.
- Write acceptance: wr_i && !full_o.
- Read acceptance: rd_i && !empty_o.
- Both acceptances are evaluated on pre-edge state and may occur in the same cycle.
- Writes while full are dropped, even if a read is accepted in the same cycle. Pointers and memory stay unchanged for the dropped write.
- Reads while empty are ignored.
- Level update: level_next = level + (wr accepted ? 1 : 0) − (rd accepted ? 2 : 0).
- Flags:
  - full_o = (level == 2^ADDR_WIDTH).
  - empty_o = (level < 2).
- An odd leftover narrow word stays stored, invisible on the read side, until its partner arrives.
- rd_data_o is forced to 0 while empty_o = 1.
- Pointer wrap-around is natural modulo 2^ADDR_WIDTH. Because depth is even, a wide read never straddles the wrap.

## Timing
- Reset values:
  - level_o = 0, full_o = 0, empty_o = 1, rd_data_o = 0.
  - w_ptr = r_ptr = 0.
  - Memory contents are not reset.
- Reset asserted mid-operation clears pointers and level immediately (asynchronously). Stored data becomes unreachable.
- Write latency: data written at edge N is readable from the cycle after edge N. When that write completes a pair, empty_o falls and rd_data_o becomes valid right after edge N.
- Read: rd_data_o is valid combinationally before the edge at which rd_i is sampled. After that edge, rd_data_o shows the next pair, or 0 if fewer than 2 words remain.
- All flags and level_o are registered-state derived, with no combinational path from wr_i or rd_i.
- Same-cycle write and read at level 1: the read is rejected (empty_o = 1 pre-edge) and level becomes 2.

## Structure
- Shared package fifo_pkg holds two items:
  - localparam function for depth (2**ADDR_WIDTH).
  - Typedef for the 2-bit {wr, rd} acceptance vector used in the controller case statement.
- One sub-module, reg_file_2r: parameterised register file with a synchronous write port and two asynchronous read ports.
- The pointer/level controller stays in the top module.

## Test plan
All scenarios use ADDR_WIDTH=2 (depth 4) and DATA_WIDTH=8.
- Basic pack: reset, then write 0x11, 0x22.
  - After the 1st write: empty_o=1, level_o=1.
  - After the 2nd write: rd_data_o=0x2211, empty_o=0, level_o=2.
  - Read: empty_o=1, rd_data_o=0x0000, level_o=0.
- Odd leftover: write 0xAA, 0xBB, 0xCC, then read once.
  - Read returns 0xBBAA.
  - Afterwards level_o=1, empty_o=1.
  - Write 0xDD: rd_data_o=0xDDCC.
- Full / drop: write 0x01..0x04, then:
  - full_o=1, level_o=4.
  - Write 0x05: dropped, level_o stays 4.
  - Two reads return 0x0201 then 0x0403.
  - Afterwards empty_o=1.
- Wrap-around: cycle 0x00..0x0B through the FIFO in bursts of 2 writes then 1 read.
  - Reads return 0x0100, 0x0302, …, 0x0B0A in order.
  - No flag glitches.
- Simultaneous events:
  - Level 3 with wr+rd: read accepted, write accepted, level_o=2.
  - Level 4 (full) with wr+rd: read accepted, write dropped, level_o=2.
- Reset mid-operation: assert rst_i asynchronously between edges at level 3.
  - Outputs go to their reset values immediately, without waiting for a clock edge.
  - After release, write 0x77, 0x88: rd_data_o=0x8877.
